// File: rtl/if_pkg.sv
// Shared types for the instruction fetch stage: queue entry layout and counter sizing.
package if_pkg;

   localparam int unsigned IF_XLEN = 32;

   typedef struct packed {
      logic [IF_XLEN-1:0] pc;
      logic [IF_XLEN-1:0] instr;
   } fetch_entry_t;

   // Bits needed to hold any value in 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Generic synchronous FIFO with clear; head is the oldest entry, valid whenever not empty.
// Clear wins over push and pop; push when full and pop when empty are ignored.
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   input  logic                   clear,
   output entry_t                 head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_en;
   logic          pop_en;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_en) - CW'(pop_en);
      end
   end

   // Storage needs no reset: entries are only read once counted in.
   always_ff @(posedge clk) begin
      if (push_en && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Pipelined RV32 fetch stage: up to MAX_OUTSTANDING iram reads in flight, FQ_DEPTH-entry queue, redirect drop counter.
// Accept T -> id_pipe_valid T+3 (T+2 with IF_FQ_BYPASS_EN); ready low holds output, queue fills, iram_req stops at zero credit.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int unsigned     XLEN            = 32,
   parameter int unsigned     FQ_DEPTH        = 4,
   parameter int unsigned     MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] PC_RESET_ADDR   = '0
) (
   input  logic              clk,
   input  logic              rst_b,
   output logic              id_pipe_valid,
   input  logic              id_pipe_ready,
   input  logic              id_pipe_flush,
   output logic [XLEN-1:0]   id_pipe_pc,
   output logic [XLEN-1:0]   id_pipe_instruction,
   input  logic              ex_branch,
   input  logic [XLEN-1:0]   ex_branch_pc,
   output logic              iram_req,
   output logic              iram_write,
   output logic [XLEN/8-1:0] iram_wstrb,
   output logic [XLEN-1:0]   iram_addr,
   output logic [XLEN-1:0]   iram_wdata,
   input  logic              iram_addr_ok,
   input  logic              iram_data_ok,
   input  logic [XLEN-1:0]   iram_rdata
);

   localparam int unsigned OW = cnt_width(MAX_OUTSTANDING);
   localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   drop_cnt;

   logic [CW-1:0]   fq_count;
   logic            fq_full;
   logic            fq_empty;
   logic            fq_push;
   logic            fq_pop;
   entry_t          fq_head;
   entry_t          fq_push_data;

   logic            credit_ok;
   logic            accept;
   logic            keep_rsp;
   logic            drop_rsp;
   logic            out_can_load;
   logic            bypass_load;

   // Credits count both in-flight reads and queued entries, so a push never meets a full queue.
   assign credit_ok = (32'(outstanding) < MAX_OUTSTANDING) &&
                      ((32'(outstanding) + 32'(fq_count)) < FQ_DEPTH);
   assign iram_req   = rst_b & credit_ok;
   assign iram_addr  = ex_branch ? ex_branch_pc : fetch_pc;
   assign iram_write = 1'b0;
   assign iram_wstrb = '0;
   assign iram_wdata = '0;

   assign accept       = iram_req & iram_addr_ok;
   assign keep_rsp     = iram_data_ok & ~ex_branch & (drop_cnt == '0);
   assign drop_rsp     = iram_data_ok & ~ex_branch & (drop_cnt != '0);
   assign out_can_load = ~id_pipe_valid | id_pipe_ready;

`ifdef IF_FQ_BYPASS_EN
   assign bypass_load = keep_rsp & fq_empty & out_can_load & ~id_pipe_flush;
`else
   assign bypass_load = 1'b0;
`endif

   assign fq_push = keep_rsp & ~bypass_load & ~fq_full;
   assign fq_pop  = ~fq_empty & out_can_load & ~id_pipe_flush;

   always_comb begin
      fq_push_data       = '0;
      fq_push_data.pc    = rsp_pc;
      fq_push_data.instr = iram_rdata;
   end

   if_fetch_fifo #(
      .DEPTH   (FQ_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_b     (rst_b),
      .push      (fq_push),
      .push_data (fq_push_data),
      .pop       (fq_pop),
      .clear     (ex_branch),
      .head      (fq_head),
      .count     (fq_count),
      .full      (fq_full),
      .empty     (fq_empty)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         fetch_pc    <= PC_RESET_ADDR;
         outstanding <= '0;
      end else begin
         if (accept)         fetch_pc <= iram_addr + XLEN'(4);
         else if (ex_branch) fetch_pc <= ex_branch_pc;
         outstanding <= outstanding + OW'(accept) - OW'(iram_data_ok);
      end
   end

   // drop_cnt is a subset of outstanding, so on redirect every old-path read still owed
   // (minus the one returning now) is marked for discard; same-cycle accepts are new-path.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rsp_pc   <= PC_RESET_ADDR;
         drop_cnt <= '0;
      end else if (ex_branch) begin
         rsp_pc   <= ex_branch_pc;
         drop_cnt <= outstanding - OW'(iram_data_ok);
      end else begin
         if (keep_rsp) rsp_pc   <= rsp_pc + XLEN'(4);
         if (drop_rsp) drop_cnt <= drop_cnt - OW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         id_pipe_valid       <= 1'b0;
         id_pipe_pc          <= '0;
         id_pipe_instruction <= '0;
      end else if (id_pipe_flush) begin
         id_pipe_valid <= 1'b0;
      end else if (bypass_load) begin
         id_pipe_valid       <= 1'b1;
         id_pipe_pc          <= rsp_pc;
         id_pipe_instruction <= iram_rdata;
      end else if (fq_pop) begin
         id_pipe_valid       <= 1'b1;
         id_pipe_pc          <= fq_head.pc;
         id_pipe_instruction <= fq_head.instr;
      end else if (id_pipe_ready) begin
         id_pipe_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: zero-wait iram model, stream, backpressure and redirect cases.
module tb_if_fetch_queue;

`ifdef IF_FQ_BYPASS_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        id_pipe_valid;
   logic        id_pipe_ready;
   logic        id_pipe_flush;
   logic [31:0] id_pipe_pc;
   logic [31:0] id_pipe_instruction;
   logic        ex_branch;
   logic [31:0] ex_branch_pc;
   logic        iram_req;
   logic        iram_write;
   logic [3:0]  iram_wstrb;
   logic [31:0] iram_addr;
   logic [31:0] iram_wdata;
   logic        iram_addr_ok;
   logic        iram_data_ok;
   logic [31:0] iram_rdata;

   int          compared = 0;
   int          mismatched = 0;
   bit          aok;
   bit          den;
   logic [31:0] rsp_q [$];
   logic [31:0] nxt;

   always #5 clk = ~clk;

   if_fetch_queue #(
      .XLEN            (32),
      .FQ_DEPTH        (4),
      .MAX_OUTSTANDING (2),
      .PC_RESET_ADDR   (32'h100)
   ) dut (
      .clk                 (clk),
      .rst_b               (rst_b),
      .id_pipe_valid       (id_pipe_valid),
      .id_pipe_ready       (id_pipe_ready),
      .id_pipe_flush       (id_pipe_flush),
      .id_pipe_pc          (id_pipe_pc),
      .id_pipe_instruction (id_pipe_instruction),
      .ex_branch           (ex_branch),
      .ex_branch_pc        (ex_branch_pc),
      .iram_req            (iram_req),
      .iram_write          (iram_write),
      .iram_wstrb          (iram_wstrb),
      .iram_addr           (iram_addr),
      .iram_wdata          (iram_wdata),
      .iram_addr_ok        (iram_addr_ok),
      .iram_data_ok        (iram_data_ok),
      .iram_rdata          (iram_rdata)
   );

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   // One clock: drive RAM handshakes at the falling edge, track accepts, return at the next falling edge.
   task automatic cyc();
      logic        acc;
      logic [31:0] acc_addr;
      iram_addr_ok = aok;
      iram_data_ok = den && (rsp_q.size() != 0);
      iram_rdata   = iram_data_ok ? ram_word(rsp_q[0]) : 32'h0;
      #1;
      acc      = iram_req && iram_addr_ok;
      acc_addr = iram_addr;
      @(posedge clk);
      if (iram_data_ok) void'(rsp_q.pop_front());
      if (acc) rsp_q.push_back(acc_addr);
      @(negedge clk);
      ex_branch     = 1'b0;
      id_pipe_flush = 1'b0;
   endtask

   task automatic expect_stream(input string tag, input logic [31:0] start, input int n);
      int w;
      w = 0;
      while (id_pipe_valid !== 1'b1 && w < 12) begin
         cyc();
         w++;
      end
      for (int k = 0; k < n; k++) begin
         if (k != 0) cyc();
         chk({tag, "_vld"}, 32'(id_pipe_valid), 32'd1);
         chk({tag, "_pc"}, id_pipe_pc, start + 32'(4 * k));
         chk({tag, "_ins"}, id_pipe_instruction, ram_word(start + 32'(4 * k)));
      end
   endtask

   initial begin
      id_pipe_ready = 1'b1;
      id_pipe_flush = 1'b0;
      ex_branch     = 1'b0;
      ex_branch_pc  = 32'h0;
      iram_addr_ok  = 1'b0;
      iram_data_ok  = 1'b0;
      iram_rdata    = 32'h0;
      aok = 1'b0;
      den = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_req", 32'(iram_req), 32'd0);
      chk("rst_vld", 32'(id_pipe_valid), 32'd0);
      chk("rst_pc", id_pipe_pc, 32'h0);
      chk("rst_ins", id_pipe_instruction, 32'h0);

      rst_b = 1'b1;
      aok = 1'b1;
      den = 1'b1;
      #1;
      chk("first_req", 32'(iram_req), 32'd1);
      chk("first_addr", iram_addr, 32'h100);
      chk("wr_tie", {31'b0, iram_write} | {28'b0, iram_wstrb} | iram_wdata, 32'h0);

      // Zero-wait stream: first valid LAT cycles after the first accept, then one pc per cycle.
      for (int c = 0; c < 8; c++) begin
         cyc();
         chk("strm_vld", 32'(id_pipe_valid), (c >= LAT - 1) ? 32'd1 : 32'd0);
         if (c >= LAT - 1) chk("strm_pc", id_pipe_pc, 32'h100 + 32'(4 * (c - LAT + 1)));
      end
      nxt = 32'h100 + 32'(4 * (8 - LAT));

      id_pipe_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         chk("bp_vld", 32'(id_pipe_valid), 32'd1);
         chk("bp_pc", id_pipe_pc, nxt);
      end
      chk("bp_req_low", 32'(iram_req), 32'd0);

      id_pipe_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         nxt = nxt + 32'h4;
         cyc();
         chk("res_vld", 32'(id_pipe_valid), 32'd1);
         chk("res_pc", id_pipe_pc, nxt);
      end

      // Redirect while two old-path reads are in flight.
      den = 1'b0;
      cyc();
      chk("cap_req", 32'(iram_req), 32'd0);
      ex_branch = 1'b1;
      id_pipe_flush = 1'b1;
      ex_branch_pc = 32'h200;
      aok = 1'b0;
      #1;
      chk("r2_addr", iram_addr, 32'h200);
      cyc();
      chk("r2_flush", 32'(id_pipe_valid), 32'd0);
      aok = 1'b1;
      den = 1'b1;
      expect_stream("r2", 32'h200, 3);

      // Redirect accepted in the same cycle is new-path and kept.
      ex_branch = 1'b1;
      id_pipe_flush = 1'b1;
      ex_branch_pc = 32'h300;
      den = 1'b0;
      #1;
      chk("sc_req", 32'(iram_req), 32'd1);
      chk("sc_addr", iram_addr, 32'h300);
      cyc();
      #1;
      chk("sc_fetch", iram_addr, 32'h304);
      chk("sc_flush", 32'(id_pipe_valid), 32'd0);
      den = 1'b1;
      expect_stream("sc", 32'h300, 2);

      // Redirect with no accept for three cycles: target must still be fetched.
      ex_branch = 1'b1;
      id_pipe_flush = 1'b1;
      ex_branch_pc = 32'h400;
      aok = 1'b0;
      cyc();
      chk("na_flush", 32'(id_pipe_valid), 32'd0);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("na_req", 32'(iram_req), 32'd1);
         chk("na_addr", iram_addr, 32'h400);
         cyc();
      end
      aok = 1'b1;
      expect_stream("na", 32'h400, 2);

      // Response returning in the redirect cycle, one more old read still owed.
      den = 1'b0;
      cyc();
      ex_branch = 1'b1;
      id_pipe_flush = 1'b1;
      ex_branch_pc = 32'h500;
      den = 1'b1;
      #1;
      chk("rr_req", 32'(iram_req), 32'd0);
      cyc();
      chk("rr_flush", 32'(id_pipe_valid), 32'd0);
      expect_stream("rr", 32'h500, 2);

      // Flush alone kills only the output register; the queue carries on.
      id_pipe_flush = 1'b1;
      cyc();
      chk("fl_vld", 32'(id_pipe_valid), 32'd0);
      cyc();
      chk("fl_vld2", 32'(id_pipe_valid), 32'd1);
      chk("fl_pc", id_pipe_pc, 32'h508);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
